// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the word-copy DMA engine.
package mem_copy_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Word-copy master for the single-port data memory: reads LEN words from SRC and
// writes them to DST, two cycles per word, with abort and a one-cycle done pulse.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [LEN_W-1:0]  words_done_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e            state_q;
  logic [ADDR_W-1:0] src_ptr_q;
  logic [ADDR_W-1:0] dst_ptr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  words_done_q;
  logic              aborted_q;

  // start_i and abort_i are level inputs with no handshake back: start_i is honoured
  // only in IDLE, abort_i only in READ/WRITE, and start wins if both arrive in IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      remaining_q  <= '0;
      words_done_q <= '0;
      aborted_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            src_ptr_q    <= src_addr_i;
            dst_ptr_q    <= dst_addr_i;
            remaining_q  <= len_i;
            words_done_q <= '0;
            aborted_q    <= 1'b0;
            state_q      <= (len_i != '0) ? READ : FINISH;
          end
        end
        READ: begin
          if (abort_i) begin
            aborted_q <= 1'b1;
            state_q   <= FINISH;
          end else begin
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          // The write in this cycle always lands and is counted, even when aborting.
          src_ptr_q    <= src_ptr_q + ADDR_W'(1);
          dst_ptr_q    <= dst_ptr_q + ADDR_W'(1);
          words_done_q <= words_done_q + LEN_W'(1);
          remaining_q  <= remaining_q - LEN_W'(1);
          if (abort_i) begin
            aborted_q <= 1'b1;
            state_q   <= FINISH;
          end else if (remaining_q == LEN_W'(1)) begin
            state_q   <= FINISH;
          end else begin
            state_q   <= READ;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      READ: begin
        mem_read_o = 1'b1;
        mem_addr_o = src_ptr_q;
      end
      WRITE: begin
        mem_write_o = 1'b1;
        mem_addr_o  = dst_ptr_q;
        mem_wdata_o = mem_rdata_i;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q == READ) || (state_q == WRITE);
  assign done_o       = (state_q == FINISH);
  assign aborted_o    = aborted_q;
  assign words_done_o = words_done_q;

endmodule
